// File: rtl/nv_nvdla_sdp_wdma_seq.sv
// SDP write-DMA sequencer: one write command plus its data beats per output line, walking
// line -> height -> surface. Optional stall counter under `NVDLA_SDP_WDMA_PERF_EN.
module nv_nvdla_sdp_wdma_seq #(
    parameter int unsigned DW          = 256,
    parameter int unsigned AW          = 64,
    parameter int unsigned AM_AW       = 5,
    parameter int unsigned ATOM_C_LOG2 = 3
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                op_load,
    input  logic [12:0]         reg2dp_width,
    input  logic [12:0]         reg2dp_height,
    input  logic [12:0]         reg2dp_channel,
    input  logic [31:0]         reg2dp_dst_base_addr_high,
    input  logic [31-AM_AW:0]   reg2dp_dst_base_addr_low,
    input  logic [31-AM_AW:0]   reg2dp_dst_line_stride,
    input  logic [31-AM_AW:0]   reg2dp_dst_surface_stride,
    input  logic                dp2wdma_valid,
    output logic                dp2wdma_ready,
    input  logic [DW-1:0]       dp2wdma_pd,
    output logic                dma_wr_req_valid,
    input  logic                dma_wr_req_ready,
    output logic                dma_wr_req_type,
    output logic [AW-1:0]       dma_wr_req_addr,
    output logic [12:0]         dma_wr_req_size,
    output logic                dma_wr_req_ack,
    output logic [DW-1:0]       dma_wr_req_data,
    input  logic                dma_wr_rsp_complete,
    output logic                dp2reg_done,
    output logic [31:0]         dp2reg_wdma_stall
);

    localparam int unsigned LW = AW - AM_AW;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StWaitAck} state_e;

    state_e        state_q;
    logic [12:0]   x_q;
    logic [12:0]   y_q;
    logic [9:0]    s_q;
    logic [LW-1:0] line_addr_q;
    logic [LW-1:0] surf_addr_q;
    logic          done_q;

    logic [LW-1:0] base_addr;
    logic [LW-1:0] line_stride;
    logic [LW-1:0] surf_stride;
    logic [LW-1:0] next_surf_addr;
    logic          last_line;
    logic          data_hs;

    assign base_addr      = LW'({reg2dp_dst_base_addr_high, reg2dp_dst_base_addr_low});
    assign line_stride    = LW'(reg2dp_dst_line_stride);
    assign surf_stride    = LW'(reg2dp_dst_surface_stride);
    assign next_surf_addr = surf_addr_q + surf_stride;

    // Final line of the cube: last row of the last surface; only its command asks for an ack.
    assign last_line = (y_q == reg2dp_height) &&
                       ({3'b000, s_q} == (reg2dp_channel >> ATOM_C_LOG2));

    assign data_hs = (state_q == StData) && dp2wdma_valid && dma_wr_req_ready;

    always_comb begin
        dp2wdma_ready    = 1'b0;
        dma_wr_req_valid = 1'b0;
        dma_wr_req_type  = 1'b0;
        dma_wr_req_addr  = '0;
        dma_wr_req_size  = '0;
        dma_wr_req_ack   = 1'b0;
        dma_wr_req_data  = '0;
        unique case (state_q)
            StCmd: begin
                dma_wr_req_valid = 1'b1;
                dma_wr_req_type  = 1'b1;
                dma_wr_req_addr  = {line_addr_q, {AM_AW{1'b0}}};
                dma_wr_req_size  = reg2dp_width;
                dma_wr_req_ack   = last_line;
            end
            StData: begin
                dp2wdma_ready    = dma_wr_req_ready;
                dma_wr_req_valid = dp2wdma_valid;
                dma_wr_req_data  = dp2wdma_pd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            line_addr_q <= '0;
            surf_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (op_load) begin
                        state_q     <= StCmd;
                        surf_addr_q <= base_addr;
                        line_addr_q <= base_addr;
                        x_q         <= '0;
                        y_q         <= '0;
                        s_q         <= '0;
                    end
                end
                StCmd: begin
                    if (dma_wr_req_ready) begin
                        state_q <= StData;
                        x_q     <= '0;
                    end
                end
                StData: begin
                    if (data_hs) begin
                        if (x_q == reg2dp_width) begin
                            x_q <= '0;
                            if (last_line) begin
                                state_q <= StWaitAck;
                            end else begin
                                state_q <= StCmd;
                                if (y_q == reg2dp_height) begin
                                    y_q         <= '0;
                                    s_q         <= s_q + 10'd1;
                                    surf_addr_q <= next_surf_addr;
                                    line_addr_q <= next_surf_addr;
                                end else begin
                                    y_q         <= y_q + 13'd1;
                                    line_addr_q <= line_addr_q + line_stride;
                                end
                            end
                        end else begin
                            x_q <= x_q + 13'd1;
                        end
                    end
                end
                StWaitAck: begin
                    if (dma_wr_rsp_complete) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dp2reg_done = done_q;

`ifdef NVDLA_SDP_WDMA_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && op_load) begin
            stall_q <= '0;
        end else if (dma_wr_req_valid && !dma_wr_req_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign dp2reg_wdma_stall = stall_q;
`else
    assign dp2reg_wdma_stall = 32'd0;
`endif

endmodule

// File: doc/nv_nvdla_sdp_wdma_seq.md
Name: nv_nvdla_sdp_wdma_seq

Overview:
Write-side sequencer for SDP: accepts the post-processed datapath stream and emits one write command plus its data beats per line of the output cube.
Walks the cube as line, then height, then surface, from the reg2dp layout registers.
Sits between the SDP output and the DMA write interface (mcif/cvif write mux).
Raises done only after the single acked final write completes.

Parameters:
DW, 256, datapath/DMA data width in bits (one atom per beat)
AW, 64, DMA byte-address width
AM_AW, 5, log2 of atom size in bytes; low address bits are always zero
ATOM_C_LOG2, 3, log2 of channels per surface

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  async active-low reset
op_load  in  1  1-cycle layer start pulse
reg2dp_width  in  13  line length in atoms minus 1
reg2dp_height  in  13  lines per surface minus 1
reg2dp_channel  in  13  channels minus 1
reg2dp_dst_base_addr_high  in  32  base address [63:32]
reg2dp_dst_base_addr_low  in  32-AM_AW  base address [31:AM_AW]
reg2dp_dst_line_stride  in  32-AM_AW  line stride in atoms
reg2dp_dst_surface_stride  in  32-AM_AW  surface stride in atoms
dp2wdma_valid  in  1  data valid
dp2wdma_ready  out  1  data ready
dp2wdma_pd  in  DW  data atom
dma_wr_req_valid  out  1  request valid
dma_wr_req_ready  in  1  request ready
dma_wr_req_type  out  1  1 = command beat, 0 = data beat
dma_wr_req_addr  out  AW  command byte address
dma_wr_req_size  out  13  command atoms minus 1 (= reg2dp_width)
dma_wr_req_ack  out  1  command requires completion ack
dma_wr_req_data  out  DW  data beat payload
dma_wr_rsp_complete  in  1  1-cycle completion pulse for the acked command
dp2reg_done  out  1  1-cycle layer done pulse
dp2reg_wdma_stall  out  32  stall cycle count

Behaviour:
- Reset: FSM IDLE. All outputs 0. All counters and address registers 0.
- States and transitions:
  - IDLE → CMD on op_load. Latch base into surf_addr and line_addr; clear x/y/s counters.
  - CMD: dma_wr_req_valid=1, type=1. addr = {line_addr, AM_AW'b0} truncated to AW; size = reg2dp_width.
    - ack=1 only when y==reg2dp_height and s==surf_last, where surf_last = reg2dp_channel>>ATOM_C_LOG2.
    - On valid&ready → DATA; x=0.
  - DATA: dp2wdma_ready = dma_wr_req_ready.
    - dma_wr_req_valid = dp2wdma_valid; type=0; data=dp2wdma_pd. Combinational pass-through, zero latency.
    - Each handshake increments x. The beat with x==reg2dp_width ends the line:
      - If not the last line: advance y; if y wraps, advance s. Go to CMD.
      - If the last line: go to WAIT_ACK.
  - WAIT_ACK: on dma_wr_rsp_complete, pulse dp2reg_done for exactly 1 cycle and go to IDLE.
- Address arithmetic, modulo 2^(AW-AM_AW), wrap silently:
  - Next line: line_addr += line_stride.
  - New surface: surf_addr += surface_stride and line_addr = new surf_addr.
- dp2wdma_ready is 0 in IDLE, CMD and WAIT_ACK.
- op_load outside IDLE is ignored.
- dma_wr_rsp_complete outside WAIT_ACK is ignored. A complete pulse in the same cycle as the last data handshake is also ignored; it must arrive later.
- Request valid, once asserted, holds with stable payload until ready (CMD state; in DATA, stability is inherited from upstream).
- Counter widths: x, y 13 bits; s 10 bits.
- Async reset mid-layer returns to IDLE immediately. No done pulse is issued.
- Zero-size cube (all reg fields 0): 1 command with ack=1, 1 data beat, then done.

Optional Feature:
NVDLA_SDP_WDMA_PERF_EN
- Defined: dp2reg_wdma_stall increments, saturating at 0xFFFFFFFF, each cycle dma_wr_req_valid=1 and dma_wr_req_ready=0. Cleared on op_load.
- Undefined: dp2reg_wdma_stall tied to 0 and no counter logic is present.

Test Plan:
- width=3, height=0, channel=7, base_low=0x100, ready always 1 → 1 cmd at addr 0x2000 with size 3 and ack=1; 4 data beats; complete at +5 cycles → done 1 cycle.
- width=0, height=2, channel=15, line_stride=0x10, surf_stride=0x100, base=0 → 6 cmds at atom addrs 0,0x10,0x20,0x100,0x110,0x120; only the last has ack=1.
- Random dma_wr_req_ready (50%) with width=7 → commands held stable while stalled; dp2wdma_ready mirrors req_ready in DATA; no beat lost or duplicated (scoreboard).
- complete pulse during DATA or on the last data handshake cycle → ignored; done only after a later pulse in WAIT_ACK.
- rstn asserted mid-DATA, then op_load → clean restart from base, no spurious done.
- PERF_EN defined, req_ready held 0 for 10 cycles in CMD → stall=10; op_load clears it; undefined → stall reads 0.
